// File: rtl/ex_redirect_ctrl.sv
// ex_redirect_ctrl
//   Pipeline recovery sequencer for WB-stage exceptions and ERTN.
//   A trigger in IDLE raises flush_all in the same cycle and latches the
//   redirect target: EENTRY for an exception, ERA for ERTN, and an exception
//   wins if both fire. The target is then offered to IF under a valid/ready
//   handshake. Fetch responses that were already in flight when the flush
//   happened are marked stale (inst_discard) until they have all returned.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   wb_ex, ertn_flush    WB exception / ERTN, already qualified by wb_valid
//   csr_eentry, csr_era  redirect target sources
//   if_outstanding       accepted fetches whose data_ok has not yet retired
//                        (includes one returning this cycle)
//   inst_data_ok         fetch response this cycle
//   if_redirect_rdy      IF accepts redirect_pc
//   flush_all            clear all stage valids (combinational, IDLE only)
//   redirect_valid       redirect_pc is valid
//   redirect_pc          latched fetch target
//   inst_discard         this cycle's inst_data_ok is stale
//   busy                 recovery in progress; IF holds its PC update
//   ex_lost              sticky: a trigger arrived while busy
module ex_redirect_ctrl #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wb_ex,
  input  logic             ertn_flush,
  input  logic [31:0]      csr_eentry,
  input  logic [31:0]      csr_era,
  input  logic [CNT_W-1:0] if_outstanding,
  input  logic             inst_data_ok,
  input  logic             if_redirect_rdy,
  output logic             flush_all,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             inst_discard,
  output logic             busy,
  output logic             ex_lost
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2
  } state_e;

  state_e           state, state_nxt;
  logic [31:0]      tgt, tgt_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             trig;
  logic             out_nz;
  logic             cnt_nz;

  assign trig   = wb_ex | ertn_flush;
  assign out_nz = (if_outstanding != '0);
  assign cnt_nz = (cnt != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      tgt     <= '0;
      cnt     <= '0;
      ex_lost <= 1'b0;
    end else begin
      state <= state_nxt;
      tgt   <= tgt_nxt;
      cnt   <= cnt_nxt;
      // Triggers during recovery cannot be honoured; flag them for debug.
      if (busy && trig)
        ex_lost <= 1'b1;
    end
  end

  always_comb begin
    state_nxt      = state;
    tgt_nxt        = tgt;
    cnt_nxt        = cnt;
    flush_all      = 1'b0;
    redirect_valid = 1'b0;
    inst_discard   = 1'b0;
    busy           = 1'b1;
    unique case (state)
      IDLE: begin
        busy      = 1'b0;
        flush_all = trig;
        // Track the in-flight count every cycle; a response retiring now
        // is not part of what must be drained later.
        cnt_nxt   = if_outstanding - CNT_W'(inst_data_ok & out_nz);
        if (trig) begin
          inst_discard = inst_data_ok & out_nz;
          tgt_nxt      = wb_ex ? csr_eentry : csr_era;
          state_nxt    = REDIRECT;
        end
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        // cnt==0 responses are not ours to drop, and cnt must not wrap.
        inst_discard   = inst_data_ok & cnt_nz;
        cnt_nxt        = cnt - CNT_W'(inst_discard);
        if (if_redirect_rdy)
          state_nxt = (cnt_nxt != '0) ? DRAIN : IDLE;
      end
      DRAIN: begin
        inst_discard = inst_data_ok & cnt_nz;
        cnt_nxt      = cnt - CNT_W'(inst_discard);
        if (cnt_nxt == '0)
          state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Target is always visible; redirect_valid alone qualifies it.
  assign redirect_pc = tgt;

endmodule

// File: tb/tb_ex_redirect_ctrl.sv
// Directed bench for ex_redirect_ctrl. Inputs change 1ns after the rising
// edge; outputs are sampled 4ns later, well before the next edge.
module tb_ex_redirect_ctrl;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             resetn;
  logic             wb_ex, ertn_flush;
  logic [31:0]      csr_eentry, csr_era;
  logic [CNT_W-1:0] if_outstanding;
  logic             inst_data_ok, if_redirect_rdy;
  logic             flush_all, redirect_valid, inst_discard, busy, ex_lost;
  logic [31:0]      redirect_pc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_redirect_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn),
    .wb_ex(wb_ex), .ertn_flush(ertn_flush),
    .csr_eentry(csr_eentry), .csr_era(csr_era),
    .if_outstanding(if_outstanding), .inst_data_ok(inst_data_ok),
    .if_redirect_rdy(if_redirect_rdy),
    .flush_all(flush_all), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_discard(inst_discard),
    .busy(busy), .ex_lost(ex_lost)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  initial begin
    resetn = 1'b0; wb_ex = 1'b0; ertn_flush = 1'b0;
    csr_eentry = 32'h1c008000; csr_era = 32'h1c000100;
    if_outstanding = '0; inst_data_ok = 1'b0; if_redirect_rdy = 1'b0;
    #12;
    chk("rst_flush", flush_all, 0);
    chk("rst_rv", redirect_valid, 0);
    chk("rst_pc", redirect_pc, 0);
    chk("rst_disc", inst_discard, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lost", ex_lost, 0);
    resetn = 1'b1;
    tick();

    // 1: exception, nothing in flight, IF ready at once
    wb_ex = 1'b1; if_redirect_rdy = 1'b1; settle();
    chk("t1_flush", flush_all, 1);
    chk("t1_disc", inst_discard, 0);
    tick(); wb_ex = 1'b0; settle();
    chk("t1_rv", redirect_valid, 1);
    chk("t1_pc", redirect_pc, 32'h1c008000);
    chk("t1_flush_busy", flush_all, 0);
    tick(); settle();
    chk("t1_idle", busy, 0);
    chk("t1_rv_off", redirect_valid, 0);

    // 2: ERTN, two in flight, one returns in the trigger cycle
    ertn_flush = 1'b1; if_outstanding = 2'd2; inst_data_ok = 1'b1;
    if_redirect_rdy = 1'b0; settle();
    chk("t2_flush", flush_all, 1);
    chk("t2_disc_trig", inst_discard, 1);
    tick(); ertn_flush = 1'b0; inst_data_ok = 1'b0; if_outstanding = '0;
    if_redirect_rdy = 1'b1; settle();
    chk("t2_rv", redirect_valid, 1);
    chk("t2_pc", redirect_pc, 32'h1c000100);
    tick(); if_redirect_rdy = 1'b0; settle();
    chk("t2_drain_busy", busy, 1);
    chk("t2_drain_rv", redirect_valid, 0);
    inst_data_ok = 1'b1; #1;
    chk("t2_drain_disc", inst_discard, 1);
    tick(); settle();
    chk("t2_idle", busy, 0);
    chk("t2_third_keep", inst_discard, 0);
    inst_data_ok = 1'b0;

    // 3: both triggers, exception wins
    wb_ex = 1'b1; ertn_flush = 1'b1; settle();
    chk("t3_flush", flush_all, 1);
    tick(); wb_ex = 1'b0; ertn_flush = 1'b0; if_redirect_rdy = 1'b1; settle();
    chk("t3_pc", redirect_pc, 32'h1c008000);
    tick(); if_redirect_rdy = 1'b0; settle();
    chk("t3_idle", busy, 0);

    // 4: IF stalls 5 cycles, two stale responses drain during the wait
    csr_eentry = 32'h1c00a000; wb_ex = 1'b1; if_outstanding = 2'd2;
    tick(); wb_ex = 1'b0; if_outstanding = '0; csr_eentry = 32'h0badf00d;
    for (int i = 0; i < 5; i++) begin
      // data_ok on waits 1, 3 (stale) and 4 (cnt already 0: kept)
      inst_data_ok = (i == 1 || i == 3 || i == 4);
      settle();
      chk("t4_rv", redirect_valid, 1);
      chk("t4_pc", redirect_pc, 32'h1c00a000);
      chk("t4_disc", inst_discard, (i == 1 || i == 3) ? 1 : 0);
      tick();
    end
    inst_data_ok = 1'b0; if_redirect_rdy = 1'b1; settle();
    chk("t4_rv_last", redirect_valid, 1);
    tick(); if_redirect_rdy = 1'b0; settle();
    chk("t4_no_drain", busy, 0);

    // 5: trigger while in DRAIN is dropped and recorded
    csr_eentry = 32'h1c00b000; wb_ex = 1'b1; if_outstanding = 2'd2;
    tick(); wb_ex = 1'b0; if_outstanding = '0; if_redirect_rdy = 1'b1;
    tick(); if_redirect_rdy = 1'b0; settle();
    chk("t5_drain", busy, 1);
    chk("t5_lost0", ex_lost, 0);
    csr_eentry = 32'h1c00c000; wb_ex = 1'b1; #1;
    chk("t5_noflush", flush_all, 0);
    tick(); wb_ex = 1'b0; settle();
    chk("t5_lost", ex_lost, 1);
    chk("t5_pc", redirect_pc, 32'h1c00b000);
    inst_data_ok = 1'b1; settle();
    chk("t5_disc_a", inst_discard, 1);
    tick(); settle();
    chk("t5_disc_b", inst_discard, 1);
    tick(); inst_data_ok = 1'b0; settle();
    chk("t5_idle", busy, 0);
    chk("t5_lost_sticky", ex_lost, 1);

    // 6: async reset in DRAIN with three in flight
    wb_ex = 1'b1; if_outstanding = 2'd3;
    tick(); wb_ex = 1'b0; if_outstanding = '0; if_redirect_rdy = 1'b1;
    tick(); if_redirect_rdy = 1'b0; settle();
    chk("t6_drain", busy, 1);
    resetn = 1'b0; #1;
    chk("t6_busy", busy, 0);
    chk("t6_rv", redirect_valid, 0);
    chk("t6_pc", redirect_pc, 0);
    chk("t6_lost", ex_lost, 0);
    chk("t6_flush", flush_all, 0);
    tick(); resetn = 1'b1;
    tick(); if_outstanding = 2'd1; inst_data_ok = 1'b1; settle();
    chk("t6_keep", inst_discard, 0);
    inst_data_ok = 1'b0; if_outstanding = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
